// File: rtl/eddy_sample_conditioner.sv
// eddy_sample_conditioner
//   Sits directly after the eddy-current SPI master. Each rising edge of the
//   master's done level captures one X/Y conversion. The block removes the
//   calibration offset with saturation, averages 2^AVG_LOG2 corrected samples
//   and hands the averaged pair to the register layer over valid/ready.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              1 = accept samples, 0 = flush partial average and idle
//   done                SPI master done level (sensor_x/y valid while high)
//   sensor_x/y          raw signed samples
//   offset_x/y          signed calibration offsets (quasi-static)
//   out_x/y, out_valid  averaged result and its valid flag
//   out_ready           consumer accepts when out_valid & out_ready
//   sample_cnt          number of captured raw samples (wraps)
//   overrun             sticky drop indicator, cleared by clr_overrun
module eddy_sample_conditioner #(
    parameter int AVG_LOG2 = 2,
    parameter int DATA_W   = 18
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     done,
    input  logic signed [DATA_W-1:0] sensor_x,
    input  logic signed [DATA_W-1:0] sensor_y,
    input  logic signed [DATA_W-1:0] offset_x,
    input  logic signed [DATA_W-1:0] offset_y,
    output logic signed [DATA_W-1:0] out_x,
    output logic signed [DATA_W-1:0] out_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              sample_cnt,
    output logic                     overrun,
    input  logic                     clr_overrun
);

    // Accumulator holds the exact sum of 2^AVG_LOG2 full-range samples.
    localparam int AW = DATA_W + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CW-1:0] AVG_LAST = CW'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {IDLE, CORR, ACCUM, OUT} state_t;

    // Offset subtraction done one bit wider, then clamped back to DATA_W.
    function automatic logic signed [DATA_W-1:0] sat_sub(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [DATA_W:0] diff;
        diff = {a[DATA_W-1], a} - {b[DATA_W-1], b};
        if (diff[DATA_W] != diff[DATA_W-1])
            sat_sub = diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                   : {1'b0, {(DATA_W-1){1'b1}}};
        else
            sat_sub = diff[DATA_W-1:0];
    endfunction

    // Floor-rounded mean: arithmetic shift of the exact sum.
    function automatic logic signed [DATA_W-1:0] avg_of(input logic signed [AW-1:0] sum);
        avg_of = DATA_W'(sum >>> AVG_LOG2);
    endfunction

    state_t                   state_q;
    logic                     done_q;
    logic signed [DATA_W-1:0] raw_x_q, raw_y_q;
    logic signed [DATA_W-1:0] corr_x_q, corr_y_q;
    logic signed [AW-1:0]     acc_x_q, acc_y_q;
    logic [CW-1:0]            avg_cnt_q;
    logic signed [DATA_W-1:0] out_x_q, out_y_q;
    logic                     out_valid_q;
    logic [15:0]              sample_cnt_q;
    logic                     overrun_q;

    logic                     rise;
    logic                     ovr_set;
    logic signed [DATA_W-1:0] corr_x_d, corr_y_d;
    logic signed [AW-1:0]     acc_x_d, acc_y_d;
    logic signed [DATA_W-1:0] res_x_d, res_y_d;

    assign rise = done & ~done_q;

    always_comb begin
        corr_x_d = sat_sub(raw_x_q, offset_x);
        corr_y_d = sat_sub(raw_y_q, offset_y);
        acc_x_d  = acc_x_q + AW'(corr_x_q);
        acc_y_d  = acc_y_q + AW'(corr_y_q);
        res_x_d  = avg_of(acc_x_q);
        res_y_d  = avg_of(acc_y_q);
        // Drops: a rise the FSM cannot take, or a finished result that finds
        // the output register still occupied.
        ovr_set  = enable & ((rise & (state_q != IDLE)) |
                             ((state_q == OUT) & out_valid_q & ~out_ready));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            done_q       <= 1'b0;
            raw_x_q      <= '0;
            raw_y_q      <= '0;
            corr_x_q     <= '0;
            corr_y_q     <= '0;
            acc_x_q      <= '0;
            acc_y_q      <= '0;
            avg_cnt_q    <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_valid_q  <= 1'b0;
            sample_cnt_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            done_q <= done;

            // Acceptance clears valid; a load in OUT below overrides this.
            if (out_valid_q && out_ready)
                out_valid_q <= 1'b0;

            if (!enable) begin
                state_q   <= IDLE;
                acc_x_q   <= '0;
                acc_y_q   <= '0;
                avg_cnt_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            raw_x_q      <= sensor_x;
                            raw_y_q      <= sensor_y;
                            sample_cnt_q <= sample_cnt_q + 16'd1;
                            state_q      <= CORR;
                        end
                    end
                    CORR: begin
                        corr_x_q <= corr_x_d;
                        corr_y_q <= corr_y_d;
                        state_q  <= ACCUM;
                    end
                    ACCUM: begin
                        acc_x_q <= acc_x_d;
                        acc_y_q <= acc_y_d;
                        if (avg_cnt_q == AVG_LAST) begin
                            state_q <= OUT;
                        end else begin
                            avg_cnt_q <= avg_cnt_q + CW'(1);
                            state_q   <= IDLE;
                        end
                    end
                    OUT: begin
                        if (!out_valid_q || out_ready) begin
                            out_x_q     <= res_x_d;
                            out_y_q     <= res_y_d;
                            out_valid_q <= 1'b1;
                        end
                        acc_x_q   <= '0;
                        acc_y_q   <= '0;
                        avg_cnt_q <= '0;
                        state_q   <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end

            // Clear has priority over a same-cycle set.
            if (clr_overrun)
                overrun_q <= 1'b0;
            else if (ovr_set)
                overrun_q <= 1'b1;
        end
    end

    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_valid  = out_valid_q;
    assign sample_cnt = sample_cnt_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_eddy_sample_conditioner.sv
// Bench for eddy_sample_conditioner: one instance with AVG_LOG2=0 and one with
// AVG_LOG2=2 share clock, reset, data and offsets but have private done and
// out_ready. Expected averages are queued when stimulus is issued and a
// monitor per instance pops and compares on every accepted output.
module tb_eddy_sample_conditioner;
    localparam int W = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, enable, clr_overrun;
    logic          done0, done2, out_ready0, out_ready2;
    logic [W-1:0]  sensor_x, sensor_y, offset_x, offset_y;
    logic [W-1:0]  out_x0, out_y0, out_x2, out_y2;
    logic          out_valid0, out_valid2, overrun0, overrun2;
    logic [15:0]   sample_cnt0, sample_cnt2;

    int vectors = 0;
    int fails   = 0;
    logic [2*W-1:0] q0[$];
    logic [2*W-1:0] q2[$];

    eddy_sample_conditioner #(.AVG_LOG2(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .done(done0),
        .sensor_x(sensor_x), .sensor_y(sensor_y),
        .offset_x(offset_x), .offset_y(offset_y),
        .out_x(out_x0), .out_y(out_y0), .out_valid(out_valid0),
        .out_ready(out_ready0), .sample_cnt(sample_cnt0),
        .overrun(overrun0), .clr_overrun(clr_overrun)
    );

    eddy_sample_conditioner #(.AVG_LOG2(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .done(done2),
        .sensor_x(sensor_x), .sensor_y(sensor_y),
        .offset_x(offset_x), .offset_y(offset_y),
        .out_x(out_x2), .out_y(out_y2), .out_valid(out_valid2),
        .out_ready(out_ready2), .sample_cnt(sample_cnt2),
        .overrun(overrun2), .clr_overrun(clr_overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors sample 1 time unit after the negedge where stimulus changes,
    // well away from the rising edge that performs the handshake.
    always begin
        logic [2*W-1:0] e;
        @(negedge clk);
        #1;
        if (rst_n && out_valid0 && out_ready0) begin
            if (q0.size() == 0) begin
                vectors++;
                fails++;
                $display("FAIL dut0_unexpected: got x=0x%0h y=0x%0h, expected no output", out_x0, out_y0);
            end else begin
                e = q0.pop_front();
                check("dut0_out_x", 32'(out_x0), 32'(e[2*W-1:W]));
                check("dut0_out_y", 32'(out_y0), 32'(e[W-1:0]));
            end
        end
    end

    always begin
        logic [2*W-1:0] e;
        @(negedge clk);
        #1;
        if (rst_n && out_valid2 && out_ready2) begin
            if (q2.size() == 0) begin
                vectors++;
                fails++;
                $display("FAIL dut2_unexpected: got x=0x%0h y=0x%0h, expected no output", out_x2, out_y2);
            end else begin
                e = q2.pop_front();
                check("dut2_out_x", 32'(out_x2), 32'(e[2*W-1:W]));
                check("dut2_out_y", 32'(out_y2), 32'(e[W-1:0]));
            end
        end
    end

    // One conversion into dut2, then enough idle cycles to drain the FSM.
    task automatic send2(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        sensor_x = x;
        sensor_y = y;
        done2    = 1'b1;
        @(negedge clk);
        done2 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b1; clr_overrun = 1'b0;
        done0 = 1'b0; done2 = 1'b0; out_ready0 = 1'b1; out_ready2 = 1'b1;
        sensor_x = '0; sensor_y = '0; offset_x = '0; offset_y = '0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_out_x",      32'(out_x2),      32'h0);
        check("rst_out_y",      32'(out_y2),      32'h0);
        check("rst_out_valid",  32'(out_valid2),  32'h0);
        check("rst_sample_cnt", 32'(sample_cnt2), 32'h0);
        check("rst_overrun",    32'(overrun2),    32'h0);
        check("rst_out_valid0", 32'(out_valid0),  32'h0);
        rst_n = 1'b1;

        // Reset asserted while the fourth sample sits in ACCUM
        send2(18'h5, 18'h5);
        send2(18'h5, 18'h5);
        send2(18'h5, 18'h5);
        check("pre_rst_cnt", 32'(sample_cnt2), 32'd3);
        @(negedge clk);
        done2 = 1'b1;
        @(negedge clk);
        done2 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_cnt",   32'(sample_cnt2), 32'd0);
        check("midrst_valid", 32'(out_valid2),  32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("postrst_valid", 32'(out_valid2),  32'h0);
        check("postrst_cnt",   32'(sample_cnt2), 32'd0);

        // Pass-through with offset and 3-cycle latency
        offset_x = 18'h00010;
        offset_y = 18'h00001;
        q0.push_back({18'h000F0, 18'h3FFFE});
        @(negedge clk);
        sensor_x = 18'h00100;
        sensor_y = 18'h3FFFF;
        done0    = 1'b1;
        @(negedge clk);
        done0 = 1'b0;
        check("lat_e0", 32'(out_valid0), 32'h0);
        @(negedge clk);
        check("lat_e1", 32'(out_valid0), 32'h0);
        @(negedge clk);
        check("lat_e2", 32'(out_valid0), 32'h0);
        @(negedge clk);
        check("lat_e3", 32'(out_valid0), 32'h1);
        @(negedge clk);
        check("accept_clears", 32'(out_valid0), 32'h0);
        repeat (2) @(negedge clk);

        // Saturation at both rails
        offset_x = 18'h20000;
        offset_y = 18'h00001;
        q0.push_back({18'h1FFFF, 18'h20000});
        @(negedge clk);
        sensor_x = 18'h1FFFF;
        sensor_y = 18'h20000;
        done0    = 1'b1;
        @(negedge clk);
        done0 = 1'b0;
        repeat (5) @(negedge clk);
        check("dut0_cnt", 32'(sample_cnt0), 32'd2);
        offset_x = '0;
        offset_y = '0;

        // Four-sample average with floor rounding
        send2(18'h00001, 18'h3FFFF);
        send2(18'h00002, 18'h3FFFF);
        send2(18'h00003, 18'h3FFFF);
        check("avg_no_early", 32'(out_valid2), 32'h0);
        q2.push_back({18'h00001, 18'h3FFFE});
        send2(18'h3FFFE, 18'h3FFFE);
        check("avg_cnt4", 32'(sample_cnt2), 32'd4);

        // Consumer stalled: first result held, second dropped
        out_ready2 = 1'b0;
        q2.push_back({18'h00004, 18'h00008});
        repeat (4) send2(18'h00004, 18'h00008);
        check("ovr_first_valid", 32'(out_valid2), 32'h1);
        check("ovr_first_none",  32'(overrun2),   32'h0);
        repeat (4) send2(18'h00064, 18'h3FF9C);
        check("ovr_set",    32'(overrun2),    32'h1);
        check("ovr_hold_x", 32'(out_x2),      32'h4);
        check("ovr_hold_y", 32'(out_y2),      32'h8);
        check("ovr_cnt",    32'(sample_cnt2), 32'd12);
        @(negedge clk);
        out_ready2 = 1'b1;
        @(negedge clk);
        check("ovr_drained", 32'(out_valid2), 32'h0);
        clr_pulse();
        check("ovr_clr", 32'(overrun2), 32'h0);

        // Second rise while the first sample is still in flight
        @(negedge clk);
        sensor_x = 18'h01B58;
        sensor_y = 18'h01B58;
        done2    = 1'b1;
        @(negedge clk);
        done2 = 1'b0;
        @(negedge clk);
        done2 = 1'b1;
        @(negedge clk);
        done2 = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_rise_ovr", 32'(overrun2),    32'h1);
        check("busy_rise_cnt", 32'(sample_cnt2), 32'd13);
        clr_pulse();
        check("busy_clr", 32'(overrun2), 32'h0);

        // Disable discards the partial average and ignores rises
        send2(18'h003E8, 18'h003E8);
        check("part_no_valid", 32'(out_valid2),  32'h0);
        check("part_cnt",      32'(sample_cnt2), 32'd14);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        done2 = 1'b1;
        repeat (2) @(negedge clk);
        check("dis_cnt", 32'(sample_cnt2), 32'd14);
        check("dis_ovr", 32'(overrun2),    32'h0);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check("en_done_high_cnt", 32'(sample_cnt2), 32'd14);
        done2 = 1'b0;
        repeat (2) @(negedge clk);
        q2.push_back({18'h00019, 18'h3FFE6});
        send2(18'h0000A, 18'h3FFF6);
        send2(18'h00014, 18'h3FFEC);
        send2(18'h0001E, 18'h3FFE2);
        send2(18'h00029, 18'h3FFD7);
        check("en_cnt", 32'(sample_cnt2), 32'd18);
        check("en_ovr", 32'(overrun2),    32'h0);

        repeat (4) @(negedge clk);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q2_drained", 32'(q2.size()), 32'd0);
        check("dut0_ovr",   32'(overrun0),  32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
